// File: rtl/ysyx_22040386_mem_pkg.sv
// Shared types and constants for the IF/LS memory arbiter: FSM states, owner
// encoding, CLINT window and well-known CLINT register addresses.
package ysyx_22040386_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam logic [63:0] CLINT_BASE    = 64'h0000_0000_0200_0000;
  localparam logic [63:0] CLINT_MASK    = 64'h0000_0000_FFFF_0000;
  localparam logic [63:0] ADDR_MTIME    = 64'h0000_0000_0200_BFF8;
  localparam logic [63:0] ADDR_MTIMECMP = 64'h0000_0000_0200_4000;
  localparam logic [63:0] ERR_RDATA     = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic clint_hit(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [63:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/ysyx_22040386_mem_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins; on a tie the
// requester that did not win last time is granted.
module ysyx_22040386_rr_arb2
  import ysyx_22040386_mem_pkg::*;
(
  input  logic   req_if_i,
  input  logic   req_ls_i,
  input  owner_e rr_last_i,
  output logic   gnt_if_o,
  output logic   gnt_ls_o
);

  always_comb begin
    gnt_if_o = 1'b0;
    gnt_ls_o = 1'b0;
    if (req_if_i && req_ls_i) begin
      if (rr_last_i == OWN_LS) begin
        gnt_if_o = 1'b1;
      end else begin
        gnt_ls_o = 1'b1;
      end
    end else begin
      gnt_if_o = req_if_i;
      gnt_ls_o = req_ls_i;
    end
  end

endmodule

// File: rtl/ysyx_22040386_mem_arbiter.sv
// Shares the pmem port and the CLINT register port between instruction fetch
// and load/store, one outstanding transaction at a time, with a WAIT timeout.
module ysyx_22040386_mem_arbiter #(
  parameter logic [63:0] CLINT_BASE = 64'h0000_0000_0200_0000,
  parameter logic [63:0] CLINT_MASK = 64'h0000_0000_FFFF_0000,
  parameter logic [7:0]  TIMEOUT    = 8'd255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_valid,
  input  logic [63:0] i_if_addr,
  output logic        o_if_ready,
  output logic        o_if_rvalid,
  output logic [63:0] o_if_rdata,
  output logic        o_if_err,
  input  logic        i_ls_valid,
  input  logic        i_ls_we,
  input  logic [63:0] i_ls_addr,
  input  logic [63:0] i_ls_wdata,
  input  logic [7:0]  i_ls_wmask,
  output logic        o_ls_ready,
  output logic        o_ls_rvalid,
  output logic [63:0] o_ls_rdata,
  output logic        o_ls_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [63:0] o_mem_addr,
  output logic [63:0] o_mem_wdata,
  output logic [7:0]  o_mem_wmask,
  input  logic        i_mem_rvalid,
  input  logic [63:0] i_mem_rdata,
  output logic        o_clint_ren,
  output logic        o_clint_wen,
  output logic [63:0] o_clint_addr,
  output logic [63:0] o_clint_wdata,
  input  logic [63:0] i_clint_rdata
);
  import ysyx_22040386_mem_pkg::*;

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  owner_e      rr_last_q, rr_last_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wmask_q, wmask_d;
  logic        is_clint_q, is_clint_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        idle_s;
  logic        gnt_if_s;
  logic        gnt_ls_s;
  logic        mem_act_s;
  logic        clint_act_s;
  logic        resp_if_s;
  logic        resp_ls_s;

  assign idle_s = (state_q == S_IDLE);

  ysyx_22040386_rr_arb2 u_arb (
    .req_if_i  (i_if_valid & idle_s),
    .req_ls_i  (i_ls_valid & idle_s),
    .rr_last_i (rr_last_q),
    .gnt_if_o  (gnt_if_s),
    .gnt_ls_o  (gnt_ls_s)
  );

  // Ready is masked while reset is asserted so every output reads 0 in reset.
  assign o_if_ready = gnt_if_s & i_rst_n;
  assign o_ls_ready = gnt_ls_s & i_rst_n;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_last_d  = rr_last_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    is_clint_d = is_clint_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_if_s) begin
          owner_d    = OWN_IF;
          rr_last_d  = OWN_IF;
          we_d       = 1'b0;
          addr_d     = i_if_addr;
          wdata_d    = 64'd0;
          wmask_d    = 8'd0;
          is_clint_d = clint_hit(i_if_addr, CLINT_BASE, CLINT_MASK);
          state_d    = S_ISSUE;
        end else if (gnt_ls_s) begin
          owner_d    = OWN_LS;
          rr_last_d  = OWN_LS;
          we_d       = i_ls_we;
          addr_d     = i_ls_addr;
          wdata_d    = i_ls_wdata;
          wmask_d    = i_ls_wmask;
          is_clint_d = clint_hit(i_ls_addr, CLINT_BASE, CLINT_MASK);
          state_d    = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (is_clint_q) begin
          // Instruction fetch from the CLINT window is a bus error.
          if (owner_q == OWN_IF) begin
            rdata_d = ERR_RDATA;
            err_d   = 1'b1;
          end else begin
            rdata_d = we_q ? 64'd0 : i_clint_rdata;
            err_d   = 1'b0;
          end
          state_d = S_RESP;
        end else begin
          cnt_d   = 8'd0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_mem_rvalid) begin
          rdata_d = we_q ? 64'd0 : i_mem_rdata;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == TIMEOUT) begin
          rdata_d = ERR_RDATA;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        rdata_d = 64'd0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_IF;
      rr_last_q  <= OWN_LS;
      we_q       <= 1'b0;
      addr_q     <= 64'd0;
      wdata_q    <= 64'd0;
      wmask_q    <= 8'd0;
      is_clint_q <= 1'b0;
      cnt_q      <= 8'd0;
      rdata_q    <= 64'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_last_q  <= rr_last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      is_clint_q <= is_clint_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // pmem payload is presented from ISSUE through WAIT; the request itself pulses once.
  assign mem_act_s   = ((state_q == S_ISSUE) || (state_q == S_WAIT)) && !is_clint_q;
  assign o_mem_req   = (state_q == S_ISSUE) && !is_clint_q;
  assign o_mem_we    = mem_act_s & we_q;
  assign o_mem_addr  = mem_act_s ? addr_q  : 64'd0;
  assign o_mem_wdata = mem_act_s ? wdata_q : 64'd0;
  assign o_mem_wmask = mem_act_s ? wmask_q : 8'd0;

  assign clint_act_s   = (state_q == S_ISSUE) && is_clint_q && (owner_q == OWN_LS);
  assign o_clint_ren   = clint_act_s & !we_q;
  assign o_clint_wen   = clint_act_s & we_q;
  assign o_clint_addr  = clint_act_s ? addr_q  : 64'd0;
  assign o_clint_wdata = clint_act_s ? wdata_q : 64'd0;

  assign resp_if_s   = (state_q == S_RESP) && (owner_q == OWN_IF);
  assign resp_ls_s   = (state_q == S_RESP) && (owner_q == OWN_LS);
  assign o_if_rvalid = resp_if_s;
  assign o_if_rdata  = resp_if_s ? rdata_q : 64'd0;
  assign o_if_err    = resp_if_s & err_q;
  assign o_ls_rvalid = resp_ls_s;
  assign o_ls_rdata  = resp_ls_s ? rdata_q : 64'd0;
  assign o_ls_err    = resp_ls_s & err_q;

endmodule
